// File: rtl/irq_pending_arbiter.sv
// Edge-detecting sticky pending register with a priority-ordered valid/ready offer and a lost-event counter.
// Define IRQ_PENDING_ARBITER_SYNC_EN to put a 2-flop synchronizer in front of the edge detector.
module irq_pending_arbiter #(
    parameter int N  = 8,
    parameter int IW = 3,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  mask_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o,
    output logic [N-1:0]  pending_o,
    output logic          any_pending_o,
    output logic          lost_o,
    output logic [CW-1:0] lost_cnt_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] idx_d;
    logic [IW-1:0] top_idx;

    logic [N-1:0]  req_s;
    logic [N-1:0]  req_q;
    logic [N-1:0]  edge_vec;
    logic [N-1:0]  clr_vec;
    logic [N-1:0]  lost_vec;
    logic [N-1:0]  pending_d;
    logic [N-1:0]  elig;
    logic          accept;

    logic [IW:0]   lost_num;
    logic [CW:0]   lost_sum;
    logic [CW-1:0] lost_cnt_d;

`ifdef IRQ_PENDING_ARBITER_SYNC_EN
    logic [N-1:0] sync1_q;
    logic [N-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= req_i;
            sync2_q <= sync1_q;
        end
    end

    assign req_s = sync2_q;
`else
    assign req_s = req_i;
`endif

    assign accept   = valid_o & ready_i;
    assign edge_vec = req_s & ~req_q;
    assign elig     = pending_o & ~mask_i;

    // A new edge on the bit being accepted wins over the clear and is not counted as lost.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < N; i++) begin
            clr_vec[i] = accept && (idx_o == IW'(i));
        end
        pending_d = edge_vec | (pending_o & ~clr_vec);
        lost_vec  = edge_vec & pending_o & ~clr_vec;
    end

    always_comb begin
        lost_num = '0;
        for (int i = 0; i < N; i++) begin
            lost_num = lost_num + {{IW{1'b0}}, lost_vec[i]};
        end
        lost_sum   = {1'b0, lost_cnt_o} + (CW+1)'(lost_num);
        lost_cnt_d = lost_sum[CW] ? {CW{1'b1}} : lost_sum[CW-1:0];
    end

    always_comb begin
        top_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (elig[i]) begin
                top_idx = IW'(i);
            end
        end
    end

    // The offer is frozen once made; only an accept can release it.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_o;
        case (state_q)
            IDLE: begin
                if (en && (elig != '0)) begin
                    state_d = OFFER;
                    idx_d   = top_idx;
                end
            end
            OFFER: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_o         <= '0;
            req_q         <= '0;
            pending_o     <= '0;
            any_pending_o <= 1'b0;
            lost_o        <= 1'b0;
            lost_cnt_o    <= '0;
        end else begin
            state_q       <= state_d;
            idx_o         <= idx_d;
            req_q         <= req_s;
            pending_o     <= pending_d;
            any_pending_o <= |pending_d;
            lost_o        <= |lost_vec;
            lost_cnt_o    <= lost_cnt_d;
        end
    end

    assign valid_o = (state_q == OFFER);

endmodule
